// File: rtl/controle_ciclo_forno_pkg.sv
// Shared types and beep timing for the oven run-control block.
package forno_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } estado_t;

   localparam int unsigned BEEP_ON_Q     = 32'd2;
   localparam int unsigned BEEP_OFF_Q    = 32'd2;
   localparam int unsigned BEEP_PERIOD_Q = BEEP_ON_Q + BEEP_OFF_Q;

   // True while the quarter-second index falls in the sounding part of a beep.
   function automatic logic beep_on(input logic [15:0] quarter);
      return (quarter % 16'(BEEP_PERIOD_Q)) < 16'(BEEP_ON_Q);
   endfunction

endpackage

// File: rtl/controle_ciclo_forno_if.sv
// Panel/datapath signals of the oven run-control block.
interface controle_ciclo_forno_if;

   logic       Start;
   logic       Stop;
   logic       Porta;
   logic       TemR;
   logic       Tampar;
   logic       Magnetron;
   logic       Luz;
   logic       Buzzer;
   logic [1:0] Estado;

   modport master (
      output Start, Stop, Porta, TemR,
      input  Tampar, Magnetron, Luz, Buzzer, Estado
   );

   modport slave (
      input  Start, Stop, Porta, TemR,
      output Tampar, Magnetron, Luz, Buzzer, Estado
   );

endinterface

// File: rtl/controle_ciclo_forno_divisor_tick.sv
// Modulo-DIV counter with clear and enable; tick marks the wrapping cycle.
module divisor_tick #(
   parameter int unsigned DIV = 32'd4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   // Next count: clear wins, then wrap, then increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/controle_ciclo_forno.sv
// Oven run-control FSM: one-second decrement pulse, door pause and end-of-cycle beeps.
module controle_ciclo_forno
   import forno_pkg::*;
#(
   parameter int unsigned PRESCALE = 32'd50_000_000,
   parameter int unsigned N_BEEPS  = 32'd3
) (
   input  logic                  CK,
   input  logic                  nRST,
   controle_ciclo_forno_if.slave bus
);

   localparam int unsigned   N_QUARTERS = N_BEEPS * BEEP_PERIOD_Q;
   localparam int unsigned   QW         = (N_QUARTERS > 32'd1) ? $clog2(N_QUARTERS) : 32'd1;
   localparam logic [QW-1:0] Q_LAST     = QW'(N_QUARTERS - 32'd1);

   estado_t       state_q, state_d;
   logic [QW-1:0] quarter_q, quarter_d;
   logic          tampar_q, tampar_d;
   logic          magnetron_q, magnetron_d;
   logic          luz_q, luz_d;
   logic          buzzer_q, buzzer_d;

   logic sec_en_s, sec_clr_s, sec_tick_s;
   logic qtr_en_s, qtr_clr_s, qtr_tick_s;
   logic pattern_end_s;

   // Staying in RUN already implies door closed, no stop and TemR=1.
   assign sec_en_s      = (state_q == ST_RUN) && (state_d == ST_RUN);
   assign sec_clr_s     = (state_q != ST_RUN) && (state_d == ST_RUN);
   assign qtr_en_s      = (state_q == ST_DONE);
   assign qtr_clr_s     = (state_q != ST_DONE) && (state_d == ST_DONE);
   assign pattern_end_s = qtr_tick_s && (quarter_q == Q_LAST);

   divisor_tick #(.DIV(PRESCALE)) u_segundo (
      .clk_i  (CK),
      .rst_ni (nRST),
      .en_i   (sec_en_s),
      .clr_i  (sec_clr_s),
      .tick_o (sec_tick_s)
   );

   divisor_tick #(.DIV(PRESCALE / 32'd4)) u_quarto (
      .clk_i  (CK),
      .rst_ni (nRST),
      .en_i   (qtr_en_s),
      .clr_i  (qtr_clr_s),
      .tick_o (qtr_tick_s)
   );

   // Next-state logic, priority Stop > door open > TemR=0 > Start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.Stop && bus.Start && bus.Porta && bus.TemR) state_d = ST_RUN;
            else                                                 state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.Stop)        state_d = ST_IDLE;
            else if (!bus.Porta) state_d = ST_PAUSE;
            else if (!bus.TemR)  state_d = ST_DONE;
            else                 state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (bus.Stop)                     state_d = ST_IDLE;
            else if (bus.Start && bus.Porta)  state_d = bus.TemR ? ST_RUN : ST_IDLE;
            else                              state_d = ST_PAUSE;
         end
         ST_DONE: begin
            if (bus.Stop || !bus.Porta || pattern_end_s) state_d = ST_IDLE;
            else                                        state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Quarter index and registered outputs derived from the next state.
   always_comb begin
      quarter_d = quarter_q;
      if (qtr_clr_s) begin
         quarter_d = '0;
      end else if (pattern_end_s) begin
         quarter_d = '0;
      end else if (qtr_tick_s) begin
         quarter_d = quarter_q + QW'(1);
      end else begin
         quarter_d = quarter_q;
      end
      tampar_d    = sec_tick_s;
      magnetron_d = (state_d == ST_RUN);
      luz_d       = (state_d == ST_RUN) || (state_d == ST_PAUSE) || !bus.Porta;
      buzzer_d    = (state_d == ST_DONE) && beep_on(16'(quarter_d));
   end

   // State, beep index and output registers.
   always_ff @(posedge CK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         quarter_q   <= '0;
         tampar_q    <= 1'b0;
         magnetron_q <= 1'b0;
         luz_q       <= 1'b0;
         buzzer_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         quarter_q   <= quarter_d;
         tampar_q    <= tampar_d;
         magnetron_q <= magnetron_d;
         luz_q       <= luz_d;
         buzzer_q    <= buzzer_d;
      end
   end

   assign bus.Tampar    = tampar_q;
   assign bus.Magnetron = magnetron_q;
   assign bus.Luz       = luz_q;
   assign bus.Buzzer    = buzzer_q;
   assign bus.Estado    = state_q;

endmodule
